mem_access_ctrl: RTL and testbench

- Memory-stage front end that sits directly upstream of the word-addressed data memory (32 × 32-bit array, reads and writes on negedge clk, word index address, read_write 2'b10 = read, 2'b01 = write).
- Takes EX/MEM load/store requests with byte addresses and sizes. Drives the memory's read_write, address and write-data.
- Implements sub-word stores as a 2-cycle read-modify-write with pipeline stall. Sign/zero-extends loads and flags misaligned or out-of-range accesses.

---
 rtl/mem_pkg.sv | 53 +++++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage front end: op codes, memory command codes,
// the FSM state type and the op decoder.
package mem_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b01;
    localparam logic [1:0] RW_READ  = 2'b10;

    typedef enum logic {ST_IDLE, ST_RMW_WR} state_e;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    typedef struct packed {
        logic  legal;
        logic  store;
        logic  is_unsigned;
        size_e size;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [3:0] op);
        op_info_t info;
        info = '{legal: 1'b1, store: op[3], is_unsigned: 1'b0, size: SZ_WORD};
        case (op)
            OP_LB, OP_SB: info.size = SZ_BYTE;
            OP_LH, OP_SH: info.size = SZ_HALF;
            OP_LW, OP_SW: info.size = SZ_WORD;
            OP_LBU: begin
                info.size        = SZ_BYTE;
                info.is_unsigned = 1'b1;
            end
            OP_LHU: begin
                info.size        = SZ_HALF;
                info.is_unsigned = 1'b1;
            end
            default: info.legal = 1'b0;
        endcase
        return info;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extract and extend load lanes, merge store lanes
// into a previously read word. Purely combinational.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] merge_word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        ld_data = rdata;
        case (size)
            SZ_BYTE: ld_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: ld_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ld_data = rdata;
        endcase

        st_word = merge_word;
        case (size)
            SZ_BYTE: st_word[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (lane[1]) st_word[31:16] = wdata[15:0];
                else         st_word[15:0]  = wdata[15:0];
            end
            default: st_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage front end: issues word reads/writes, runs sub-word stores as a
// stalled read-modify-write, extends loads and flags bad accesses.
// Optional per-kind op counters are built when MEM_ACCESS_STATS_EN is defined.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [3:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    input  logic          debug_on,
    input  logic          stop_debug,
    input  logic [31:0]   mem_rdata,
    output logic [1:0]    mem_read_write,
    output logic [31:0]   mem_address,
    output logic [31:0]   mem_wdata,
    output logic          stall,
    output logic [31:0]   ld_data,
    output logic          ld_valid,
    output logic          acc_err
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0]   stat_loads,
    output logic [15:0]   stat_stores,
    output logic [15:0]   stat_rmw,
    output logic [15:0]   stat_errs
`endif
);

    localparam logic [AW-2:0] IDX_LIMIT = (AW-1)'(DEPTH);

    state_e         state, state_next;
    op_info_t       info;
    logic [AW-3:0]  word_idx;
    logic           misaligned, out_of_range, fault, frozen;
    logic           addr_en, ld_capture, merge_capture, err_set;
    logic [31:0]    merge_word, ld_ext, st_word;

    assign info         = decode_op(req_op);
    assign word_idx     = req_addr[AW-1:2];
    assign misaligned   = (info.size == SZ_HALF && req_addr[0]) ||
                          (info.size == SZ_WORD && req_addr[1:0] != 2'b00);
    assign out_of_range = {1'b0, word_idx} >= IDX_LIMIT;
    assign fault        = !info.legal || misaligned || out_of_range;
    assign frozen       = debug_on || stop_debug;
    assign mem_address  = addr_en ? 32'(word_idx) : 32'h0;

    mem_lane_align u_lane_align (
        .lane        (req_addr[1:0]),
        .size        (info.size),
        .is_unsigned (info.is_unsigned),
        .rdata       (mem_rdata),
        .merge_word  (merge_word),
        .wdata       (req_wdata),
        .ld_data     (ld_ext),
        .st_word     (st_word)
    );

    // Reset and debug freeze both force the memory port quiet.
    always_comb begin
        state_next     = state;
        mem_read_write = RW_IDLE;
        mem_wdata      = 32'h0;
        addr_en        = 1'b0;
        stall          = 1'b0;
        ld_capture     = 1'b0;
        merge_capture  = 1'b0;
        err_set        = 1'b0;
        if (rst) begin
            state_next = ST_IDLE;
        end else if (frozen) begin
            stall = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (fault) begin
                            err_set = 1'b1;
                        end else if (!info.store) begin
                            mem_read_write = RW_READ;
                            addr_en        = 1'b1;
                            ld_capture     = 1'b1;
                        end else if (info.size == SZ_WORD) begin
                            mem_read_write = RW_WRITE;
                            addr_en        = 1'b1;
                            mem_wdata      = req_wdata;
                        end else begin
                            mem_read_write = RW_READ;
                            addr_en        = 1'b1;
                            stall          = 1'b1;
                            merge_capture  = 1'b1;
                            state_next     = ST_RMW_WR;
                        end
                    end
                end
                ST_RMW_WR: begin
                    mem_read_write = RW_WRITE;
                    addr_en        = 1'b1;
                    mem_wdata      = st_word;
                    state_next     = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ld_data    <= 32'h0;
            ld_valid   <= 1'b0;
            acc_err    <= 1'b0;
            merge_word <= 32'h0;
        end else begin
            state    <= state_next;
            ld_valid <= ld_capture;
            acc_err  <= err_set;
            if (ld_capture)    ld_data    <= ld_ext;
            if (merge_capture) merge_word <= mem_rdata;
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    logic store_done, rmw_done;

    assign store_done = (mem_read_write == RW_WRITE);
    assign rmw_done   = store_done && (state == ST_RMW_WR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_loads  <= 16'h0;
            stat_stores <= 16'h0;
            stat_rmw    <= 16'h0;
            stat_errs   <= 16'h0;
        end else begin
            if (ld_capture) stat_loads  <= sat_inc(stat_loads);
            if (store_done) stat_stores <= sat_inc(stat_stores);
            if (rmw_done)   stat_rmw    <= sat_inc(stat_rmw);
            if (err_set)    stat_errs   <= sat_inc(stat_errs);
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural memory and a transaction-level
// reference model compared against the DUT every cycle.
module tb_mem_access_ctrl;

    localparam logic [3:0] LB  = 4'b0000;
    localparam logic [3:0] LH  = 4'b0001;
    localparam logic [3:0] LW  = 4'b0011;
    localparam logic [3:0] LBU = 4'b0100;
    localparam logic [3:0] LHU = 4'b0101;
    localparam logic [3:0] SB  = 4'b1000;
    localparam logic [3:0] SH  = 4'b1001;
    localparam logic [3:0] SW  = 4'b1011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        debug_on = 1'b0;
    logic        stop_debug = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [1:0]  mem_read_write;
    logic [31:0] mem_address, mem_wdata, ld_data;
    logic        stall, ld_valid, acc_err;
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_rmw, stat_errs;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] mem [32];
    bit          mem_loaded = 1'b0;

    logic [31:0] ref_mem [32];
    bit          m_rmw = 1'b0;
    logic [31:0] m_merge = 32'h0;
    bit          exp_ld_valid = 1'b0;
    bit          exp_err = 1'b0;
    logic [31:0] exp_ld_data = 32'h0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DEPTH(32), .AW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .debug_on       (debug_on),
        .stop_debug     (stop_debug),
        .mem_rdata      (mem_rdata),
        .mem_read_write (mem_read_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .stall          (stall),
        .ld_data        (ld_data),
        .ld_valid       (ld_valid),
        .acc_err        (acc_err)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .stat_loads     (stat_loads),
        .stat_stores    (stat_stores),
        .stat_rmw       (stat_rmw),
        .stat_errs      (stat_errs)
`endif
    );

    function automatic logic [31:0] preload(input int i);
        if (i == 20) return 32'h0000_0AAA;
        if (i == 1)  return 32'h1122_3344;
        return 32'h1000_0000 + 32'(i);
    endfunction

    // Downstream data memory: acts on the falling edge.
    always @(negedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= preload(i);
            mem_loaded <= 1'b1;
        end else if (mem_read_write == 2'b10 && mem_address < 32) begin
            mem_rdata <= mem[mem_address[4:0]];
        end else if (mem_read_write == 2'b01 && mem_address < 32) begin
            mem[mem_address[4:0]] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic bit is_fault(input logic [3:0] op, input logic [31:0] a);
        int n = op_bytes(op);
        if (n == 0) return 1'b1;
        if (a % n != 0) return 1'b1;
        return (a >> 2) >= 32;
    endfunction

    function automatic logic [31:0] load_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v = w >> (8 * (a % 4));
        case (op_bytes(op))
            1: begin
                v = v & 32'hFF;
                if (op == LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            2: begin
                v = v & 32'hFFFF;
                if (op == LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] merge_model(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] w, input logic [31:0] d);
        int          sh = 8 * (a % 4);
        logic [31:0] mask = ((op_bytes(op) == 1) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    // Reference model: predicts this cycle's memory command and stall, checks the
    // registered outputs predicted by the previous cycle.
    task automatic model_step();
        logic [1:0]  e_rw = 2'b00;
        logic [31:0] e_addr = 32'h0, e_wd = 32'h0;
        bit          e_stall = 1'b0, n_ldv = 1'b0, n_err = 1'b0;
        logic [4:0]  idx = req_addr[6:2];
        if (rst) begin
            exp_ld_valid = 1'b0;
            exp_err      = 1'b0;
            m_rmw        = 1'b0;
        end
        check("ld_valid", 32'(ld_valid), 32'(exp_ld_valid));
        check("acc_err", 32'(acc_err), 32'(exp_err));
        if (exp_ld_valid) check("ld_data", ld_data, exp_ld_data);

        if (rst) begin
            // everything quiet
        end else if (debug_on || stop_debug) begin
            e_stall = 1'b1;
        end else if (m_rmw) begin
            e_rw   = 2'b01;
            e_addr = req_addr >> 2;
            e_wd   = merge_model(req_op, req_addr, m_merge, req_wdata);
            ref_mem[idx] = e_wd;
            m_rmw  = 1'b0;
        end else if (req_valid) begin
            if (is_fault(req_op, req_addr)) begin
                n_err = 1'b1;
            end else if (!req_op[3]) begin
                e_rw  = 2'b10;
                e_addr = req_addr >> 2;
                n_ldv = 1'b1;
                exp_ld_data = load_model(req_op, req_addr, ref_mem[idx]);
            end else if (req_op == SW) begin
                e_rw   = 2'b01;
                e_addr = req_addr >> 2;
                e_wd   = req_wdata;
                ref_mem[idx] = req_wdata;
            end else begin
                e_rw    = 2'b10;
                e_addr  = req_addr >> 2;
                e_stall = 1'b1;
                m_merge = ref_mem[idx];
                m_rmw   = 1'b1;
            end
        end
        check("mem_read_write", 32'(mem_read_write), 32'(e_rw));
        check("mem_address", mem_address, e_addr);
        check("mem_wdata", mem_wdata, e_wd);
        check("stall", 32'(stall), 32'(e_stall));
        exp_ld_valid = n_ldv;
        exp_err      = n_err;
    endtask

    // One clock cycle: drive at +1, optional async reset at +2, model compare at +3.
    task automatic tick_full(input logic v, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] d, input logic stop, input logic dbg,
                             input logic rst_lvl, input logic rst_mid);
        @(posedge clk);
        #1;
        rst        = rst_lvl;
        req_valid  = v;
        req_op     = op;
        req_addr   = a;
        req_wdata  = d;
        stop_debug = stop;
        debug_on   = dbg;
        #1;
        if (rst_mid) rst = 1'b1;
        #1;
        model_step();
    endtask

    task automatic go(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
        tick_full(1'b1, op, a, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        tick_full(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
`ifdef MEM_ACCESS_STATS_EN
        logic [15:0] loads0, stores0;
`endif
        for (int i = 0; i < 32; i++) ref_mem[i] = preload(i);

        // Reset state
        tick_full(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick_full(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reset ld_data", ld_data, 32'h0);
        check("reset rw", 32'(mem_read_write), 32'h0);
        idle();

        // Loads with extension, one-cycle latency
        go(LB, 32'h50, 32'h0);
        go(LBU, 32'h50, 32'h0);
        check("LB 0x50", ld_data, 32'hFFFF_FFAA);
        go(LH, 32'h50, 32'h0);
        check("LBU 0x50", ld_data, 32'h0000_00AA);
        go(LHU, 32'h52, 32'h0);
        check("LH 0x50", ld_data, 32'h0000_0AAA);
        idle();
        check("LHU 0x52", ld_data, 32'h0000_0000);
        idle();
        check("ld_valid drops", 32'(ld_valid), 32'h0);

        // Sub-word store RMW
        go(SB, 32'h51, 32'h0000_005C);
        check("SB read phase rw", 32'(mem_read_write), 32'h2);
        check("SB stall", 32'(stall), 32'h1);
        go(SB, 32'h51, 32'h0000_005C);
        check("SB write phase rw", 32'(mem_read_write), 32'h1);
        check("SB merged word", mem_wdata, 32'h0000_5CAA);
        go(LW, 32'h50, 32'h0);
        idle();
        check("LW after SB", ld_data, 32'h0000_5CAA);

        // Faults and boundaries
        go(LW, 32'h52, 32'h0);
        check("misaligned LW rw", 32'(mem_read_write), 32'h0);
        idle();
        check("misaligned LW acc_err", 32'(acc_err), 32'h1);
        go(LW, 32'h80, 32'h0);
        idle();
        check("out-of-range LW acc_err", 32'(acc_err), 32'h1);
        go(LH, 32'h51, 32'h0);
        go(SH, 32'h03, 32'h1234);
        go(4'b0010, 32'h00, 32'h0);
        go(SB, 32'h80, 32'h0);
        go(LB, 32'h7F, 32'h0);
        go(LW, 32'h7C, 32'h0);
        check("LB 0x7F (last byte)", ld_data, 32'h0000_0010);
        idle();
        check("LW 0x7C", ld_data, 32'h1000_001F);

        // Debug freeze of a pending load, then of an RMW write phase
        tick_full(1'b1, LW, 32'h50, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("debug_on stall", 32'(stall), 32'h1);
        go(SH, 32'h06, 32'h0000_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick_full(1'b1, SH, 32'h06, 32'h0000_BEEF, 1'b1, 1'b0, 1'b0, 1'b0);
            check("stop_debug rw", 32'(mem_read_write), 32'h0);
        end
        go(SH, 32'h06, 32'h0000_BEEF);
        check("SH merged word", mem_wdata, 32'hBEEF_3344);
        idle();
        check("memory word 1 after SH", mem[1], 32'hBEEF_3344);

        // Reset during the write phase: merged word never written
        go(SB, 32'h04, 32'h0000_0077);
        tick_full(1'b1, SB, 32'h04, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset mid-RMW rw", 32'(mem_read_write), 32'h0);
        idle();
        idle();
        check("memory word 1 after reset", mem[1], 32'hBEEF_3344);

        // Word store then load back
`ifdef MEM_ACCESS_STATS_EN
        loads0  = stat_loads;
        stores0 = stat_stores;
`endif
        go(SW, 32'h04, 32'hCAFE_F00D);
        go(LW, 32'h04, 32'h0);
        check("LW stall", 32'(stall), 32'h0);
        idle();
        check("LW after SW", ld_data, 32'hCAFE_F00D);
`ifdef MEM_ACCESS_STATS_EN
        check("stat_stores delta", 32'(stat_stores - stores0), 32'h1);
        check("stat_loads delta", 32'(stat_loads - loads0), 32'h1);
`endif
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
